seg7_scan_display: RTL and testbench
====================================

SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz).
REQ-002 SHALL have parameter REFRESH_WIDTH, default 17, prescaler bit width; must satisfy 2^REFRESH_WIDTH >= REFRESH_DIV.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named as the codebase does (CLK, RESET).
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 ENABLE  input  1  scan enable; low = display dark, scan frozen.
REQ-007 DIGIT0..DIGIT3  input  4 each  digit values from the down-counter chain; DIGIT0 = rightmost/least significant.
REQ-008 DP_IN  input  4  decimal point per digit; bit i = DIGITi; 1 = lit.
REQ-009 BLANK_LZ  input  1  1 = suppress leading zeros.
REQ-010 SEG_SELECT_OUT  output  4  active-low digit anode enables; bit i = DIGITi.
REQ-011 HEX_OUT  output  8  active-low cathodes; [7]=DP, [6:0]=g,f,e,d,c,b,a.

Function
REQ-012 SHALL count prescaler 0..REFRESH_DIV-1 while ENABLE=1, wrap to 0, and assert internal strobe the cycle it equals REFRESH_DIV-1.
REQ-013 SHALL advance 2-bit digit pointer 0->1->2->3->0 on each strobe; pointer and prescaler hold when ENABLE=0.
REQ-014 SHALL load a frame snapshot of DIGIT0..3, DP_IN and BLANK_LZ on strobe with pointer=3 (frame wrap), so one scan frame always shows a coherent value.
REQ-015 SHALL also load the snapshot on the first enabled cycle after reset (load-pending flag set by reset, cleared by any load).
REQ-016 SHALL register outputs: SEG_SELECT_OUT/HEX_OUT reflect pointer and snapshot one cycle after they change.
REQ-017 SHALL drive SEG_SELECT_OUT with exactly one bit low (bit = pointer) while ENABLE=1; all ones when ENABLE=0 (one cycle latency).
REQ-018 SHALL decode values 0-F to hex glyphs; 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, A=0x08, b=0x03, C=0x46, d=0x21, E=0x06, F=0x0E on HEX_OUT[6:0].
REQ-019 SHALL drive HEX_OUT[7] = NOT snapshot DP bit of the selected digit.
REQ-020 SHALL, when snapshot BLANK_LZ=1, blank digit i (i=3..1) if it and all higher digits are zero: HEX_OUT[6:0]=0x7F, DP still honoured; DIGIT0 never blanked.
REQ-021 SHALL give ENABLE falling on a strobe cycle priority: no advance, no snapshot load.

Reset
REQ-022 SHALL, on RESET high, immediately set prescaler=0, pointer=0, snapshot=0, load-pending=1, SEG_SELECT_OUT=4'b1111, HEX_OUT=8'hFF, independent of CLK.
REQ-023 SHALL resume from pointer 0 after reset mid-frame; no partial frame state retained.

Structure
REQ-024 SHALL place the 16-entry glyph table and blank/off constants (0x7F, 4'b1111) in the shared display package.
REQ-025 SHALL implement decode as combinational sub-module seg7_decoder (4-bit value in, 7-bit active-low segments out), reused by other display blocks.

Verification
REQ-026 REFRESH_DIV=4, ENABLE=1, DIGITs=1,2,3,4 (D3..D0), DP_IN=0 -> SEG_SELECT_OUT cycles 1110,1101,1011,0111, each held 4 cycles; HEX_OUT 0x99,0xB0,0xA4,0xF9.
REQ-027 Change DIGIT0 from 4 to 7 while pointer=1 -> digit 0 still shows 0x99 until after next frame wrap, then 0xF8.
REQ-028 BLANK_LZ=1, digits 0,0,5,0 -> D3,D2 HEX_OUT=0xFF, D1=0x92, D0=0xC0; digits 0,0,0,0 -> only D0 shows 0xC0.
REQ-029 DP_IN=4'b0100, digits 9,9,9,9 -> D2 HEX_OUT=0x10, others 0x90.
REQ-030 ENABLE low mid-slot for 10 cycles -> next cycle SEG_SELECT_OUT=1111, HEX_OUT=FF; on re-enable, same pointer resumes with prescaler count preserved.
REQ-031 Assert RESET asynchronously between clock edges at pointer=2 -> outputs 1111/FF immediately; after release scan restarts at digit 0 with fresh snapshot.

Source files
------------

// File: rtl/seg7_scan_display_pkg.sv
// Shared display definitions: hex glyph table, blank/off constants and the
// frame snapshot layout used by the multiplexed 7-segment scanner.
package seg7_scan_display_pkg;

    // Active-low segments {g,f,e,d,c,b,a} for values 0..F.
    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [7:0] HEX_OFF   = 8'hFF;

    typedef struct packed {
        logic [3:0][3:0] digit;
        logic [3:0]      dp;
        logic            blank_lz;
    } frame_t;

endpackage

// File: rtl/seg7_scan_display_decoder.sv
// Combinational hex-to-7-segment decoder (active-low segments), shared by
// display blocks.
module seg7_decoder
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_GLYPH[i_value];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment scanner with per-frame snapshot,
// decimal points, leading-zero blanking and registered outputs.
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned REFRESH_WIDTH = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic [3:0] DIGIT0,
    input  logic [3:0] DIGIT1,
    input  logic [3:0] DIGIT2,
    input  logic [3:0] DIGIT3,
    input  logic [3:0] DP_IN,
    input  logic       BLANK_LZ,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);

    localparam logic [REFRESH_WIDTH-1:0] PRESC_MAX = REFRESH_WIDTH'(REFRESH_DIV - 1);

    logic [REFRESH_WIDTH-1:0] r_presc;
    logic [1:0]               r_ptr;
    frame_t                   r_frame;
    logic                     r_load_pend;

    logic       w_strobe;
    logic       w_load;
    frame_t     w_frame_in;
    logic [3:0] w_blank;
    logic [3:0] w_digit_sel;
    logic [6:0] w_seg;

    // Strobe and load are gated by ENABLE so a disable on the strobe cycle wins.
    always_comb begin
        w_strobe            = ENABLE && (r_presc == PRESC_MAX);
        w_load              = ENABLE && (r_load_pend || (w_strobe && (r_ptr == 2'd3)));
        w_frame_in.digit    = {DIGIT3, DIGIT2, DIGIT1, DIGIT0};
        w_frame_in.dp       = DP_IN;
        w_frame_in.blank_lz = BLANK_LZ;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc     <= '0;
            r_ptr       <= '0;
            r_frame     <= '0;
            r_load_pend <= 1'b1;
        end else if (ENABLE) begin
            r_presc <= w_strobe ? '0 : r_presc + 1'b1;
            if (w_strobe) begin
                r_ptr <= r_ptr + 2'd1;
            end
            if (w_load) begin
                r_frame     <= w_frame_in;
                r_load_pend <= 1'b0;
            end
        end
    end

    // A digit is blanked only when it and every more-significant digit are zero.
    always_comb begin
        w_blank[3] = r_frame.blank_lz && (r_frame.digit[3] == 4'd0);
        w_blank[2] = w_blank[3] && (r_frame.digit[2] == 4'd0);
        w_blank[1] = w_blank[2] && (r_frame.digit[1] == 4'd0);
        w_blank[0] = 1'b0;
        w_digit_sel = r_frame.digit[r_ptr];
    end

    seg7_decoder u_decoder (
        .i_value (w_digit_sel),
        .o_seg   (w_seg)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SEG_SELECT_OUT <= ANODE_OFF;
            HEX_OUT        <= HEX_OFF;
        end else if (ENABLE) begin
            SEG_SELECT_OUT <= ~(4'b0001 << r_ptr);
            HEX_OUT        <= {~r_frame.dp[r_ptr], (w_blank[r_ptr] ? SEG_BLANK : w_seg)};
        end else begin
            SEG_SELECT_OUT <= ANODE_OFF;
            HEX_OUT        <= HEX_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with REFRESH_DIV=4: scan order,
// snapshot coherence, blanking, decimal points, enable gating and async reset.
module tb_seg7_scan_display;

    logic       CLK;
    logic       RESET;
    logic       ENABLE;
    logic [3:0] DIGIT0, DIGIT1, DIGIT2, DIGIT3;
    logic [3:0] DP_IN;
    logic       BLANK_LZ;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    seg7_scan_display #(
        .REFRESH_DIV   (4),
        .REFRESH_WIDTH (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .DIGIT0         (DIGIT0),
        .DIGIT1         (DIGIT1),
        .DIGIT2         (DIGIT2),
        .DIGIT3         (DIGIT3),
        .DP_IN          (DP_IN),
        .BLANK_LZ       (BLANK_LZ),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk_sel(input string tag, input logic [3:0] exp_sel);
        n_checks++;
        assert (SEG_SELECT_OUT === exp_sel) else begin
            n_fail++;
            $error("FAIL %s: SEG_SELECT_OUT=%b expected %b", tag, SEG_SELECT_OUT, exp_sel);
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_sel, input logic [7:0] exp_hex);
        chk_sel(tag, exp_sel);
        n_checks++;
        assert (HEX_OUT === exp_hex) else begin
            n_fail++;
            $error("FAIL %s: HEX_OUT=%h expected %h", tag, HEX_OUT, exp_hex);
        end
    endtask

    task automatic slot(input string tag, input logic [3:0] exp_sel, input logic [7:0] exp_hex,
                        input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            @(negedge CLK);
            chk(tag, exp_sel, exp_hex);
        end
    endtask

    initial begin
        RESET    = 1'b0;
        ENABLE   = 1'b0;
        DIGIT3   = 4'd1;
        DIGIT2   = 4'd2;
        DIGIT1   = 4'd3;
        DIGIT0   = 4'd4;
        DP_IN    = 4'b0000;
        BLANK_LZ = 1'b0;
        #1 RESET = 1'b1;
        #1 chk("reset_async", 4'b1111, 8'hFF);
        @(negedge CLK);
        chk("reset_hold", 4'b1111, 8'hFF);
        RESET = 1'b0;
        @(negedge CLK);
        chk("idle_disabled", 4'b1111, 8'hFF);
        ENABLE = 1'b1;

        // First enabled edge loads the snapshot; digit 0 slot begins.
        @(negedge CLK);
        chk_sel("first_slot", 4'b1110);
        slot("f1_d0", 4'b1110, 8'h99, 3);
        slot("f1_d1", 4'b1101, 8'hB0, 4);
        slot("f1_d2", 4'b1011, 8'hA4, 4);
        slot("f1_d3", 4'b0111, 8'hF9, 4);
        slot("f2_d0", 4'b1110, 8'h99, 4);

        // Inputs change mid-frame; current frame keeps the old snapshot.
        @(negedge CLK);
        chk("f2_d1", 4'b1101, 8'hB0);
        DIGIT0 = 4'd7;
        DIGIT2 = 4'd8;
        slot("f2_d1", 4'b1101, 8'hB0, 3);
        slot("f2_d2_old", 4'b1011, 8'hA4, 4);
        slot("f2_d3", 4'b0111, 8'hF9, 4);
        slot("f3_d0_new", 4'b1110, 8'hF8, 4);

        BLANK_LZ = 1'b1;
        DIGIT3 = 4'd0; DIGIT2 = 4'd0; DIGIT1 = 4'd5; DIGIT0 = 4'd0;
        slot("f3_d1", 4'b1101, 8'hB0, 4);
        slot("f3_d2_new", 4'b1011, 8'h80, 4);
        slot("f3_d3", 4'b0111, 8'hF9, 4);

        slot("lz_d0", 4'b1110, 8'hC0, 4);
        DIGIT1 = 4'd0;
        slot("lz_d1", 4'b1101, 8'h92, 4);
        slot("lz_d2", 4'b1011, 8'hFF, 4);
        slot("lz_d3", 4'b0111, 8'hFF, 4);

        slot("zero_d0", 4'b1110, 8'hC0, 4);
        BLANK_LZ = 1'b0;
        DP_IN = 4'b0100;
        DIGIT3 = 4'd9; DIGIT2 = 4'd9; DIGIT1 = 4'd9; DIGIT0 = 4'd9;
        slot("zero_d1", 4'b1101, 8'hFF, 4);
        slot("zero_d2", 4'b1011, 8'hFF, 4);
        slot("zero_d3", 4'b0111, 8'hFF, 4);

        slot("dp_d0", 4'b1110, 8'h90, 4);
        slot("dp_d1", 4'b1101, 8'h90, 4);
        slot("dp_d2", 4'b1011, 8'h10, 4);
        slot("dp_d3", 4'b0111, 8'h90, 4);

        // Disable two cycles into the digit 0 slot.
        slot("pre_dis", 4'b1110, 8'h90, 2);
        ENABLE = 1'b0;
        slot("disabled", 4'b1111, 8'hFF, 10);
        ENABLE = 1'b1;
        slot("resume_d0", 4'b1110, 8'h90, 2);
        slot("resume_d1", 4'b1101, 8'h90, 4);
        @(negedge CLK);
        chk("ptr2", 4'b1011, 8'h10);

        // Asynchronous reset between edges while digit 2 is shown.
        DIGIT3 = 4'd3; DIGIT2 = 4'd0; DIGIT1 = 4'd6; DIGIT0 = 4'd2;
        DP_IN = 4'b0000;
        #2 RESET = 1'b1;
        #1 chk("midscan_reset", 4'b1111, 8'hFF);
        @(negedge CLK);
        chk("midscan_reset_hold", 4'b1111, 8'hFF);
        RESET = 1'b0;
        @(negedge CLK);
        chk_sel("post_first", 4'b1110);
        slot("post_d0", 4'b1110, 8'hA4, 3);
        slot("post_d1", 4'b1101, 8'h82, 4);
        slot("post_d2", 4'b1011, 8'hC0, 4);
        slot("post_d3", 4'b0111, 8'hB0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
